// File: rtl/mmio_periph_regs.sv
// MMIO peripheral register file: LEDs, 7-seg, LCD strobe,
// and synchronised/debounced switch and button reads.
module mmio_periph_deb #(
  parameter int W     = 16,
  parameter int LIMIT = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [W-1:0]  s1_q, s2_q, s3_q, st_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      // Any bounce or agreement with the held value restarts the count
      if (s2_q == st_q || s2_q != s3_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(LIMIT - 1)) begin
        st_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = st_q;
endmodule

module mmio_periph_regs #(
  parameter int LED_W     = 16,
  parameter int SW_W      = 16,
  parameter int BTN_W     = 4,
  parameter int DEB_LIMIT = 50000,
  parameter int LCD_E_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             addr0,
  input  logic [31:0]      wdata,
  input  logic             en_leds,
  input  logic             en_leds7seg,
  input  logic             en_lcd,
  input  logic             en_switches,
  input  logic             en_buttons,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [BTN_W-1:0] btn_in,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic [LED_W-1:0] leds,
  output logic [7:0]       seg7_lo,
  output logic [7:0]       seg7_hi,
  output logic [10:0]      lcd_data,
  output logic             lcd_e
);
  localparam int WQ = (LED_W > 11) ? LED_W : 11;
  localparam int EW = $clog2(LCD_E_CYC + 1);

  typedef enum logic [1:0] {
    L_IDLE, L_SETUP, L_PULSE, L_HOLD
  } lcd_st_e;

  logic          wr_dly_q, rd_dly_q, a0_dly_q;
  logic [WQ-1:0] wd_dly_q;
  logic          unused_wdata;

  logic [LED_W-1:0] leds_q;
  logic [7:0]       lo_q, hi_q;
  logic [10:0]      lcd_q;
  logic             lcd_e_q;
  lcd_st_e          st_q;
  logic [EW-1:0]    ecnt_q;
  logic [31:0]      rdata_q, rd_mux;
  logic             valid_q;
  logic             lcd_busy, any_en;
  logic [SW_W-1:0]  sw_st;
  logic [BTN_W-1:0] btn_st;

  assign unused_wdata = ^wdata[31:WQ];

  // Requests arrive one cycle ahead of the decoder enables
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_dly_q <= 1'b0;
      rd_dly_q <= 1'b0;
      a0_dly_q <= 1'b0;
      wd_dly_q <= '0;
    end else begin
      wr_dly_q <= wr_req;
      rd_dly_q <= rd_req;
      a0_dly_q <= addr0;
      wd_dly_q <= wdata[WQ-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else if (wr_dly_q) begin
      if (en_leds) leds_q <= wd_dly_q[LED_W-1:0];
      if (en_leds7seg && !a0_dly_q) lo_q <= wd_dly_q[7:0];
      if (en_leds7seg && a0_dly_q)  hi_q <= wd_dly_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= L_IDLE;
      lcd_q   <= '0;
      lcd_e_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      unique case (st_q)
        L_IDLE: begin
          if (wr_dly_q && en_lcd) begin
            st_q  <= L_SETUP;
            lcd_q <= wd_dly_q[10:0];
          end
        end
        L_SETUP: begin
          st_q    <= L_PULSE;
          lcd_e_q <= 1'b1;
          ecnt_q  <= '0;
        end
        L_PULSE: begin
          if (ecnt_q == EW'(LCD_E_CYC - 1)) begin
            st_q    <= L_HOLD;
            lcd_e_q <= 1'b0;
          end else begin
            ecnt_q <= ecnt_q + EW'(1);
          end
        end
        L_HOLD: st_q <= L_IDLE;
      endcase
    end
  end

  assign lcd_busy = (st_q != L_IDLE);

  mmio_periph_deb #(.W(SW_W), .LIMIT(DEB_LIMIT)) u_sw (
    .clk(clk), .reset(reset), .raw_i(sw_in), .stable_o(sw_st)
  );

  mmio_periph_deb #(.W(BTN_W), .LIMIT(DEB_LIMIT)) u_btn (
    .clk(clk), .reset(reset), .raw_i(btn_in), .stable_o(btn_st)
  );

  assign any_en = en_leds | en_leds7seg | en_lcd
                | en_switches | en_buttons;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      en_leds:     rd_mux = 32'(leds_q);
      en_leds7seg: rd_mux = {24'b0, a0_dly_q ? hi_q : lo_q};
      en_lcd:      rd_mux = {lcd_busy, 20'b0, lcd_q};
      en_switches: rd_mux = 32'(sw_st);
      en_buttons:  rd_mux = 32'(btn_st);
      default:     rd_mux = '0;
    endcase
  end

  // A store in the same slot wins; the load is simply dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else if (rd_dly_q && !wr_dly_q && any_en) begin
      rdata_q <= rd_mux;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign leds        = leds_q;
  assign seg7_lo     = lo_q;
  assign seg7_hi     = hi_q;
  assign lcd_data    = lcd_q;
  assign lcd_e       = lcd_e_q;
endmodule
